// File: rtl/dm8_pkg.sv
// Shared types and constants for the dm8 8-bit select-and-capture deserializer.
package dm8_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [2:0] SLOT_LAST  = 3'd7;
  localparam int         SETTLE_MAX = 15;

endpackage

// File: rtl/dec3to8_e.sv
// Combinational 3-to-8 one-hot decoder; all outputs low when en is low.
module dec3to8_e (
  input  logic [2:0] sel,
  input  logic       en,
  output logic [7:0] dec
);

  always_comb begin
    dec = 8'h00;
    if (en) dec[sel] = 1'b1;
  end

endmodule

// File: rtl/dm8_capture.sv
// Steps a remote 8:1 mux through slots 0..7, samples the returned bit after a
// settle delay and presents the assembled byte on q with a one-cycle done.
module dm8_capture
  import dm8_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       e,
  input  logic       d,
  output logic [2:0] sel,
  output logic [7:0] dec,
  output logic       busy,
  output logic       done,
  output logic [7:0] q
);

  // Counter counts down to zero, so SETTLE wait cycles need a reload of SETTLE-1.
  localparam logic [3:0] RELOAD = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

  state_t     state;
  logic [3:0] cnt;
  logic [6:0] shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      sel    <= 3'd0;
      cnt    <= 4'd0;
      shadow <= 7'h00;
      q      <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          sel <= 3'd0;
          if (start && e) begin
            cnt <= RELOAD;
            if (SETTLE == 0) state <= ST_SAMPLE;
            else             state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (e) begin
            if (cnt == 4'd0) state <= ST_SAMPLE;
            else             cnt   <= cnt - 4'd1;
          end
        end
        ST_SAMPLE: begin
          if (e) begin
            // Last slot bypasses the shadow so q updates atomically on DONE entry.
            if (sel == SLOT_LAST) begin
              q     <= {d, shadow};
              state <= ST_DONE;
            end else begin
              shadow[sel] <= d;
              sel         <= sel + 3'd1;
              cnt         <= RELOAD;
              if (SETTLE == 0) state <= ST_SAMPLE;
              else             state <= ST_SETTLE;
            end
          end
        end
        ST_DONE: begin
          sel   <= 3'd0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  dec3to8_e u_dec (
    .sel (sel),
    .en  (e && ((state == ST_SETTLE) || (state == ST_SAMPLE))),
    .dec (dec)
  );

endmodule

// File: tb/tb_dm8_capture.sv
// Scoreboard bench for dm8_capture with SETTLE=1 and SETTLE=0 instances.
module tb_dm8_capture;

  logic       clk;
  logic       rst_n;
  logic       start1, e1, d1, busy1, done1;
  logic [2:0] sel1;
  logic [7:0] dec1, q1;
  logic       start0, e0, d0, busy0, done0;
  logic [2:0] sel0;
  logic [7:0] dec0, q0;
  logic [7:0] rbyte1, rbyte0;
  logic [7:0] exp_q1[$];
  logic [7:0] exp_q0[$];
  int         n_checks;
  int         n_fail;

  dm8_capture #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .e(e1), .d(d1),
    .sel(sel1), .dec(dec1), .busy(busy1), .done(done1), .q(q1)
  );

  dm8_capture #(.SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .e(e0), .d(d0),
    .sel(sel0), .dec(dec0), .busy(busy0), .done(done0), .q(q0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Remote mux models: one cycle of latency for SETTLE=1, none for SETTLE=0.
  always @(posedge clk) d1 <= rbyte1[sel1];
  assign d0 = rbyte0[sel0];

  task automatic test_reset();
    rst_n = 1'b0; start1 = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (q1 !== 8'h00)   begin n_fail++; $display("FAIL reset_q1 got=%h exp=00", q1); end
    n_checks++; if (sel1 !== 3'd0)  begin n_fail++; $display("FAIL reset_sel1 got=%0d exp=0", sel1); end
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy1 got=%b exp=0", busy1); end
    n_checks++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL reset_done1 got=%b exp=0", done1); end
    n_checks++; if (dec1 !== 8'h00) begin n_fail++; $display("FAIL reset_dec1 got=%h exp=00", dec1); end
    n_checks++; if (q0 !== 8'h00)   begin n_fail++; $display("FAIL reset_q0 got=%h exp=00", q0); end
    start1 = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy1 got=%b exp=0", busy1); end
  endtask

  task automatic test_capture_a5();
    int done_cyc, n_done, k;
    logic [7:0] exp;
    rbyte1 = 8'hA5; done_cyc = -1; n_done = 0;
    @(negedge clk); start1 = 1'b1; exp_q1.push_back(8'hA5);
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk); start1 = 1'b0;
      if (c >= 2 && c <= 16 && (c % 2) == 0) begin
        k = c / 2 - 1;
        n_checks++; if (sel1 !== 3'(k)) begin n_fail++; $display("FAIL a5_sel c=%0d got=%0d exp=%0d", c, sel1, k); end
        n_checks++; if (dec1 !== 8'(1 << k)) begin n_fail++; $display("FAIL a5_dec c=%0d got=%h exp=%h", c, dec1, 8'(1 << k)); end
      end
      if (done1 === 1'b1) begin
        n_done++; done_cyc = c;
        n_checks++; if (dec1 !== 8'h00) begin n_fail++; $display("FAIL a5_dec_done got=%h exp=00", dec1); end
        if (exp_q1.size() == 0) begin n_checks++; n_fail++; $display("FAIL a5_sb_empty got=%h exp=none", q1); end
        else begin
          exp = exp_q1.pop_front();
          n_checks++; if (q1 !== exp) begin n_fail++; $display("FAIL a5_q got=%h exp=%h", q1, exp); end
        end
      end
    end
    n_checks++; if (done_cyc != 17) begin n_fail++; $display("FAIL a5_done_cycle got=%0d exp=17", done_cyc); end
    n_checks++; if (n_done != 1)    begin n_fail++; $display("FAIL a5_done_count got=%0d exp=1", n_done); end
  endtask

  task automatic test_capture_s0();
    int done_cyc;
    logic [7:0] exp;
    logic exp_busy;
    rbyte0 = 8'h3C; done_cyc = -1;
    @(negedge clk); start0 = 1'b1; exp_q0.push_back(8'h3C);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk); start0 = 1'b0;
      exp_busy = (c >= 1 && c <= 9);
      n_checks++; if (busy0 !== exp_busy) begin n_fail++; $display("FAIL s0_busy c=%0d got=%b exp=%b", c, busy0, exp_busy); end
      if (done0 === 1'b1) begin
        done_cyc = c;
        if (exp_q0.size() == 0) begin n_checks++; n_fail++; $display("FAIL s0_sb_empty got=%h exp=none", q0); end
        else begin
          exp = exp_q0.pop_front();
          n_checks++; if (q0 !== exp) begin n_fail++; $display("FAIL s0_q got=%h exp=%h", q0, exp); end
        end
      end
    end
    n_checks++; if (done_cyc != 9) begin n_fail++; $display("FAIL s0_done_cycle got=%0d exp=9", done_cyc); end
  endtask

  task automatic test_enable_hold();
    int done_cyc;
    logic [7:0] exp;
    rbyte1 = 8'hF0; done_cyc = -1;
    @(negedge clk); start1 = 1'b1; exp_q1.push_back(8'hF0);
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk); start1 = 1'b0;
      e1 = (c >= 7 && c <= 11) ? 1'b0 : 1'b1;
      #1;
      if (c >= 7 && c <= 11) begin
        n_checks++; if (sel1 !== 3'd3)  begin n_fail++; $display("FAIL hold_sel c=%0d got=%0d exp=3", c, sel1); end
        n_checks++; if (dec1 !== 8'h00) begin n_fail++; $display("FAIL hold_dec c=%0d got=%h exp=00", c, dec1); end
      end
      if (done1 === 1'b1) begin
        done_cyc = c;
        if (exp_q1.size() == 0) begin n_checks++; n_fail++; $display("FAIL hold_sb_empty got=%h exp=none", q1); end
        else begin
          exp = exp_q1.pop_front();
          n_checks++; if (q1 !== exp) begin n_fail++; $display("FAIL hold_q got=%h exp=%h", q1, exp); end
        end
      end
    end
    e1 = 1'b1;
    n_checks++; if (done_cyc != 22) begin n_fail++; $display("FAIL hold_done_cycle got=%0d exp=22", done_cyc); end
  endtask

  task automatic test_start_ignored();
    int done_cyc, n_done;
    logic [7:0] exp;
    rbyte1 = 8'h96; done_cyc = -1; n_done = 0;
    @(negedge clk); start1 = 1'b1; exp_q1.push_back(8'h96);
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      start1 = (c == 4 || c == 17);
      if (done1 === 1'b1) begin
        n_done++; done_cyc = c;
        if (exp_q1.size() == 0) begin n_checks++; n_fail++; $display("FAIL ign_sb_empty got=%h exp=none", q1); end
        else begin
          exp = exp_q1.pop_front();
          n_checks++; if (q1 !== exp) begin n_fail++; $display("FAIL ign_q got=%h exp=%h", q1, exp); end
        end
      end
      if (c >= 18) begin
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL ign_busy c=%0d got=%b exp=0", c, busy1); end
        n_checks++; if (sel1 !== 3'd0)  begin n_fail++; $display("FAIL ign_sel c=%0d got=%0d exp=0", c, sel1); end
      end
    end
    start1 = 1'b0;
    n_checks++; if (n_done != 1)    begin n_fail++; $display("FAIL ign_done_count got=%0d exp=1", n_done); end
    n_checks++; if (done_cyc != 17) begin n_fail++; $display("FAIL ign_done_cycle got=%0d exp=17", done_cyc); end
  endtask

  task automatic test_reset_mid_frame();
    int done_cyc;
    logic [7:0] exp;
    rbyte1 = 8'h5A;
    @(negedge clk); start1 = 1'b1; exp_q1.push_back(8'h5A);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk); start1 = 1'b0;
      if (done1 === 1'b1) begin
        if (exp_q1.size() == 0) begin n_checks++; n_fail++; $display("FAIL rst_sb_empty got=%h exp=none", q1); end
        else begin
          exp = exp_q1.pop_front();
          n_checks++; if (q1 !== exp) begin n_fail++; $display("FAIL rst_first_q got=%h exp=%h", q1, exp); end
        end
      end
    end
    rbyte1 = 8'hFF;
    @(negedge clk); start1 = 1'b1; exp_q1.push_back(8'hFF);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk); start1 = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (q1 !== 8'h00)   begin n_fail++; $display("FAIL rst_async_q got=%h exp=00", q1); end
    n_checks++; if (sel1 !== 3'd0)  begin n_fail++; $display("FAIL rst_async_sel got=%0d exp=0", sel1); end
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy got=%b exp=0", busy1); end
    n_checks++; if (dec1 !== 8'h00) begin n_fail++; $display("FAIL rst_async_dec got=%h exp=00", dec1); end
    exp_q1.delete();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); start1 = 1'b1; exp_q1.push_back(8'hFF);
    done_cyc = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk); start1 = 1'b0;
      if (done1 === 1'b1) begin
        done_cyc = c;
        if (exp_q1.size() == 0) begin n_checks++; n_fail++; $display("FAIL rst_sb2_empty got=%h exp=none", q1); end
        else begin
          exp = exp_q1.pop_front();
          n_checks++; if (q1 !== exp) begin n_fail++; $display("FAIL rst_new_q got=%h exp=%h", q1, exp); end
        end
      end
    end
    n_checks++; if (done_cyc != 17) begin n_fail++; $display("FAIL rst_new_done_cycle got=%0d exp=17", done_cyc); end
  endtask

  task automatic test_start_no_enable();
    @(negedge clk); e1 = 1'b0; start1 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL noen_busy c=%0d got=%b exp=0", c, busy1); end
      n_checks++; if (sel1 !== 3'd0)  begin n_fail++; $display("FAIL noen_sel c=%0d got=%0d exp=0", c, sel1); end
    end
    start1 = 1'b0; e1 = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL noen_not_queued got=%b exp=0", busy1); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    start1 = 1'b0; e1 = 1'b1; start0 = 1'b0; e0 = 1'b1;
    rbyte1 = 8'h00; rbyte0 = 8'h00;
    test_reset();
    test_capture_a5();
    test_capture_s0();
    test_enable_hold();
    test_start_ignored();
    test_reset_mid_frame();
    test_start_no_enable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
